// File: rtl/punc_debug_pkg.sv
// Shared definitions for the PUnC debug-port scanner: record kinds, FSM states
// and register-file size.
package punc_debug_pkg;

  localparam logic [1:0] KIND_PC  = 2'd0;
  localparam logic [1:0] KIND_RF  = 2'd1;
  localparam logic [1:0] KIND_MEM = 2'd2;

  localparam int unsigned NUM_RF = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WAIT,
    ST_EMIT,
    ST_DONE
  } state_t;

  // Phase encodings match the record kind tags so the phase can be emitted directly.
  typedef enum logic [1:0] {
    PH_PC  = KIND_PC,
    PH_RF  = KIND_RF,
    PH_MEM = KIND_MEM
  } phase_t;

endpackage

// File: rtl/punc_debug_lat_counter.sv
// Loadable down-counter with a zero flag; times the debug-port read latency.
module punc_debug_lat_counter #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/punc_debug_scanner.sv
// Host-side PUnC debug-port reader: snapshots PC, walks the register file, then a
// memory window, emitting each value as a tagged record on a valid/ready stream.
module punc_debug_scanner
  import punc_debug_pkg::*;
#(
  parameter int unsigned READ_LAT = 1,
  parameter int unsigned KIND_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       mem_base,
  input  logic [15:0]       mem_count,
  output logic              busy,
  output logic              done,
  output logic [15:0]       mem_debug_addr,
  output logic [2:0]        rf_debug_addr,
  input  logic [15:0]       mem_debug_data,
  input  logic [15:0]       rf_debug_data,
  input  logic [15:0]       pc_debug_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [KIND_W-1:0] out_kind,
  output logic [15:0]       out_addr,
  output logic [15:0]       out_data
);

  state_t      state, state_nx;
  phase_t      phase;
  logic [2:0]  rf_idx;
  logic [15:0] offset;
  logic [15:0] base_q;
  logic [15:0] count_q;
  logic [15:0] mem_addr;
  logic        lat_load, lat_dec, lat_zero;
  logic        scan_end;

  punc_debug_lat_counter #(.W(2)) u_lat (
    .clk      (clk),
    .rst      (rst),
    .load     (lat_load),
    .load_val (2'(READ_LAT)),
    .dec      (lat_dec),
    .zero     (lat_zero)
  );

  assign mem_addr = base_q + offset;
  assign scan_end = ((phase == PH_RF) && (rf_idx == 3'(NUM_RF - 1)) && (count_q == '0)) ||
                    ((phase == PH_MEM) && (offset == count_q - 16'd1));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    lat_load = 1'b0;
    lat_dec  = 1'b0;
    unique case (state)
      ST_IDLE:  if (start) state_nx = ST_SETUP;
      ST_SETUP: begin
        lat_load = 1'b1;
        state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (lat_zero) state_nx = ST_EMIT;
        else          lat_dec  = 1'b1;
      end
      ST_EMIT:  if (out_ready) state_nx = scan_end ? ST_DONE : ST_SETUP;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_SETUP) || (state == ST_WAIT) || (state == ST_EMIT);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase          <= PH_PC;
      rf_idx         <= '0;
      offset         <= '0;
      base_q         <= '0;
      count_q        <= '0;
      mem_debug_addr <= '0;
      rf_debug_addr  <= '0;
      out_valid      <= 1'b0;
      out_kind       <= '0;
      out_addr       <= '0;
      out_data       <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            base_q  <= mem_base;
            count_q <= mem_count;
            phase   <= PH_PC;
            rf_idx  <= '0;
            offset  <= '0;
          end
        end
        // Debug addresses only move here, so they hold between items and in IDLE.
        ST_SETUP: begin
          if (phase == PH_RF)       rf_debug_addr  <= rf_idx;
          else if (phase == PH_MEM) mem_debug_addr <= mem_addr;
        end
        ST_WAIT: begin
          if (lat_zero) begin
            out_valid <= 1'b1;
            out_kind  <= KIND_W'(phase);
            unique case (phase)
              PH_PC: begin
                out_addr <= '0;
                out_data <= pc_debug_data;
              end
              PH_RF: begin
                out_addr <= {13'd0, rf_idx};
                out_data <= rf_debug_data;
              end
              default: begin
                out_addr <= mem_addr;
                out_data <= mem_debug_data;
              end
            endcase
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            unique case (phase)
              PH_PC: begin
                phase  <= PH_RF;
                rf_idx <= '0;
              end
              PH_RF: begin
                if (rf_idx == 3'(NUM_RF - 1)) begin
                  phase  <= PH_MEM;
                  offset <= '0;
                end else begin
                  rf_idx <= rf_idx + 3'd1;
                end
              end
              default: offset <= offset + 16'd1;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_punc_debug_scanner.sv
// Table-driven bench for punc_debug_scanner: three instances (READ_LAT 0, 1, 3)
// each paired with a debug-port model of matching latency.
module tb_punc_debug_scanner;

  typedef struct {
    logic [1:0]  kind;
    logic [15:0] addr;
    logic [15:0] data;
    int unsigned cyc;
  } rec_t;

  typedef struct {
    int unsigned inst;
    logic [15:0] base;
    logic [15:0] cnt;
    int unsigned pct;
    int unsigned pulse_at;
    int unsigned exp_n;
    int unsigned exp_cpr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] mem_base  = '0;
  logic [15:0] mem_count = '0;
  logic        start_v [3];
  logic        ready_v [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic        valid_v [3];
  logic [15:0] maddr_v [3];
  logic [2:0]  raddr_v [3];
  logic [15:0] mdata_v [3];
  logic [15:0] rdata_v [3];
  logic [1:0]  kind_v  [3];
  logic [15:0] oaddr_v [3];
  logic [15:0] odata_v [3];
  logic [15:0] pc_val = 16'h3000;

  logic [15:0] mem_arr [65536];
  logic [15:0] rf_arr  [8];

  rec_t        log_r [3][64];
  int unsigned log_n [3];
  int unsigned done_cnt [3];
  logic        hold [3];
  rec_t        prev [3];
  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;
  vec_t        vecs [8];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned LAT = (g == 2) ? 3 : g;
    logic [15:0] mpipe [4];
    logic [15:0] rpipe [4];

    punc_debug_scanner #(.READ_LAT(LAT), .KIND_W(2)) u_dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start_v[g]),
      .mem_base       (mem_base),
      .mem_count      (mem_count),
      .busy           (busy_v[g]),
      .done           (done_v[g]),
      .mem_debug_addr (maddr_v[g]),
      .rf_debug_addr  (raddr_v[g]),
      .mem_debug_data (mdata_v[g]),
      .rf_debug_data  (rdata_v[g]),
      .pc_debug_data  (pc_val),
      .out_valid      (valid_v[g]),
      .out_ready      (ready_v[g]),
      .out_kind       (kind_v[g]),
      .out_addr       (oaddr_v[g]),
      .out_data       (odata_v[g])
    );

    always @(posedge clk) begin
      mpipe[0] <= mem_arr[maddr_v[g]];
      rpipe[0] <= rf_arr[raddr_v[g]];
      for (int k = 1; k < 4; k++) begin
        mpipe[k] <= mpipe[k-1];
        rpipe[k] <= rpipe[k-1];
      end
    end

    assign mdata_v[g] = (LAT == 0) ? mem_arr[maddr_v[g]] : mpipe[(LAT == 0) ? 0 : LAT - 1];
    assign rdata_v[g] = (LAT == 0) ? rf_arr[raddr_v[g]]  : rpipe[(LAT == 0) ? 0 : LAT - 1];
  end

  function automatic logic [15:0] mem_init(input logic [15:0] a);
    if (a >= 16'h3000 && a < 16'h3004) return 16'hA0A0 + (a - 16'h3000);
    return a ^ 16'h5A5A;
  endfunction

  function automatic rec_t exp_rec(input int unsigned k, input logic [15:0] base);
    rec_t r;
    r.cyc = 0;
    if (k == 0) begin
      r.kind = 2'd0; r.addr = 16'h0000; r.data = 16'h3000;
    end else if (k < 9) begin
      r.kind = 2'd1; r.addr = 16'(k - 1); r.data = 16'h1000 + 16'(k - 1);
    end else begin
      r.kind = 2'd2; r.addr = base + 16'(k - 9); r.data = mem_init(r.addr);
    end
    return r;
  endfunction

  task automatic sample();
    @(negedge clk);
    cyc++;
    for (int g = 0; g < 3; g++) begin
      if (rst) begin
        hold[g] = 1'b0;
      end else begin
        if (hold[g]) begin
          n_cmp++;
          if (valid_v[g] !== 1'b1 || kind_v[g] !== prev[g].kind ||
              oaddr_v[g] !== prev[g].addr || odata_v[g] !== prev[g].data) begin
            n_fail++;
            $display("FAIL hold_stable inst%0d: got v=%b k=%0d a=%h d=%h, want v=1 k=%0d a=%h d=%h",
                     g, valid_v[g], kind_v[g], oaddr_v[g], odata_v[g],
                     prev[g].kind, prev[g].addr, prev[g].data);
          end
        end
        if (valid_v[g] && ready_v[g]) begin
          if (log_n[g] < 64) log_r[g][log_n[g]] = '{kind_v[g], oaddr_v[g], odata_v[g], cyc};
          log_n[g]++;
        end
        hold[g] = valid_v[g] && !ready_v[g];
        prev[g] = '{kind_v[g], oaddr_v[g], odata_v[g], cyc};
        if (done_v[g]) begin
          done_cnt[g]++;
          n_cmp++;
          if (busy_v[g] !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_at_done inst%0d: got busy=%b, want 0", g, busy_v[g]);
          end
        end
      end
    end
  endtask

  task automatic tick();
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input int unsigned g, input string name);
    n_cmp++;
    if (busy_v[g] !== 1'b0 || done_v[g] !== 1'b0 || valid_v[g] !== 1'b0 || kind_v[g] !== 2'd0 ||
        oaddr_v[g] !== 16'd0 || odata_v[g] !== 16'd0 || maddr_v[g] !== 16'd0 || raddr_v[g] !== 3'd0) begin
      n_fail++;
      $display("FAIL %s inst%0d: got b=%b d=%b v=%b k=%0d a=%h dt=%h ma=%h ra=%0d, want all 0",
               name, g, busy_v[g], done_v[g], valid_v[g], kind_v[g], oaddr_v[g], odata_v[g],
               maddr_v[g], raddr_v[g]);
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int unsigned g;
    int unsigned dc0;
    int unsigned t;
    int unsigned lim;
    bit          pulsed;
    rec_t        e;
    g = v.inst;
    pulsed = 1'b0;
    log_n[g] = 0;
    dc0 = done_cnt[g];
    mem_base = v.base;
    mem_count = v.cnt;
    start_v[g] = 1'b1;
    ready_v[g] = 1'b1;
    tick();
    start_v[g] = 1'b0;
    mem_base = 16'hDEAD;
    mem_count = 16'h0002;
    for (t = 0; t < 3000 && done_cnt[g] == dc0; t++) begin
      ready_v[g] = (v.pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < v.pct);
      start_v[g] = (v.pulse_at != 0 && !pulsed && log_n[g] == v.pulse_at);
      if (start_v[g]) pulsed = 1'b1;
      tick();
    end
    start_v[g] = 1'b0;
    ready_v[g] = 1'b1;
    n_cmp++;
    if (done_cnt[g] == dc0) begin
      n_fail++;
      $display("FAIL %s timeout: got no done after %0d cycles, want done", name, t);
    end
    repeat (10) tick();
    n_cmp++;
    if (done_cnt[g] != dc0 + 1) begin
      n_fail++;
      $display("FAIL %s done_count: got %0d, want 1", name, done_cnt[g] - dc0);
    end
    n_cmp++;
    if (log_n[g] != v.exp_n) begin
      n_fail++;
      $display("FAIL %s record_count: got %0d, want %0d", name, log_n[g], v.exp_n);
    end
    n_cmp++;
    if (busy_v[g] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy_after: got %b, want 0", name, busy_v[g]);
    end
    if (v.pulse_at != 0) begin
      n_cmp++;
      if (!pulsed) begin
        n_fail++;
        $display("FAIL %s start_pulse: got not applied, want applied at record %0d", name, v.pulse_at);
      end
    end
    lim = (log_n[g] < 64) ? log_n[g] : 64;
    for (int unsigned k = 0; k < lim; k++) begin
      e = exp_rec(k, v.base);
      n_cmp++;
      if (log_r[g][k].kind !== e.kind || log_r[g][k].addr !== e.addr || log_r[g][k].data !== e.data) begin
        n_fail++;
        $display("FAIL %s rec%0d: got k=%0d a=%h d=%h, want k=%0d a=%h d=%h", name, k,
                 log_r[g][k].kind, log_r[g][k].addr, log_r[g][k].data, e.kind, e.addr, e.data);
      end
    end
    if (v.exp_cpr != 0) begin
      for (int unsigned k = 1; k < lim; k++) begin
        n_cmp++;
        if (log_r[g][k].cyc - log_r[g][k-1].cyc != v.exp_cpr) begin
          n_fail++;
          $display("FAIL %s cycles_rec%0d: got %0d, want %0d", name, k,
                   log_r[g][k].cyc - log_r[g][k-1].cyc, v.exp_cpr);
        end
      end
    end
  endtask

  initial begin
    int unsigned t;
    int unsigned dc0;
    for (int g = 0; g < 3; g++) begin
      start_v[g] = 1'b0;
      ready_v[g] = 1'b1;
      log_n[g] = 0;
      done_cnt[g] = 0;
      hold[g] = 1'b0;
      prev[g] = '{2'd0, 16'd0, 16'd0, 0};
    end
    for (int unsigned a = 0; a < 65536; a++) mem_arr[a] = mem_init(16'(a));
    for (int unsigned i = 0; i < 8; i++) rf_arr[i] = 16'h1000 + 16'(i);

    //          inst base      cnt    pct  pulse n   cpr
    vecs[0] = '{1, 16'h0000, 16'd0, 100, 0, 9,  4};
    vecs[1] = '{1, 16'h3000, 16'd4, 100, 0, 13, 4};
    vecs[2] = '{1, 16'hFFFE, 16'd3, 100, 0, 12, 4};
    vecs[3] = '{1, 16'h3000, 16'd4, 30,  0, 13, 0};
    vecs[4] = '{1, 16'h3000, 16'd4, 100, 5, 13, 4};
    vecs[5] = '{0, 16'h3000, 16'd4, 100, 0, 13, 3};
    vecs[6] = '{2, 16'h3000, 16'd4, 100, 0, 13, 6};
    vecs[7] = '{2, 16'hFFFE, 16'd3, 30,  0, 12, 0};

    repeat (3) tick();
    for (int unsigned g = 0; g < 3; g++) check_zero(g, "reset_state");
    rst = 1'b0;
    tick();

    for (int unsigned i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset during the memory phase abandons the scan.
    dc0 = done_cnt[1];
    log_n[1] = 0;
    mem_base = 16'h3000;
    mem_count = 16'd4;
    start_v[1] = 1'b1;
    tick();
    start_v[1] = 1'b0;
    for (t = 0; t < 500 && log_n[1] < 11; t++) tick();
    n_cmp++;
    if (log_n[1] < 11) begin
      n_fail++;
      $display("FAIL midscan_reach: got %0d records, want >= 11", log_n[1]);
    end
    rst = 1'b1;
    tick();
    check_zero(1, "midscan_reset");
    rst = 1'b0;
    repeat (20) tick();
    n_cmp++;
    if (done_cnt[1] != dc0) begin
      n_fail++;
      $display("FAIL midscan_no_done: got %0d done pulses, want 0", done_cnt[1] - dc0);
    end
    n_cmp++;
    if (busy_v[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL midscan_busy: got %b, want 0", busy_v[1]);
    end
    run_vec(vecs[1], "rescan");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
